// File: rtl/qtree_pkg.sv
// Shared types and default geometry for the quadtree lookup path.
// Result entries are packed as {match, addr, data}, matching the FIFO word layout.
package qtree_pkg;

  localparam int unsigned STAGES          = 5;
  localparam int unsigned D_CNT           = 4;
  // Each search stage resolves one of four children (2 bits); the match stage adds D_CNT bits.
  localparam int unsigned TREE_ADDR_WIDTH = 2 * STAGES + D_CNT;
  localparam int unsigned TREE_DATA_WIDTH = 16;

  typedef struct packed {
    logic                       match;
    logic [TREE_ADDR_WIDTH-1:0] addr;
    logic [TREE_DATA_WIDTH-1:0] data;
  } qtree_resp_t;

endpackage

// File: rtl/qtree_sc_fifo.sv
// Single-clock show-ahead FIFO with synchronous active-high reset.
// A write while full succeeds only when a read happens in the same cycle.
module qtree_sc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           rd_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_rd, do_wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_rd   = rd_i && !empty_o;
  assign do_wr   = wr_i && (!full_o || do_rd);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wptr_q <= wptr_q + PTR_W'(1);
      if (do_rd) rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/qtree_lookup_buf.sv
// Credit-gated front end for the fixed-latency quadtree pipeline: admits lookups only when
// result space is guaranteed, buffers results, and keeps hit/miss statistics.
module qtree_lookup_buf
  import qtree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TREE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = TREE_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  input  logic [DATA_WIDTH-1:0]             req_data_i,
  output logic                              req_ready_o,
  output logic                              tree_valid_o,
  output logic [DATA_WIDTH-1:0]             tree_data_o,
  input  logic                              tree_valid_i,
  input  logic                              tree_match_i,
  input  logic [ADDR_WIDTH-1:0]             tree_addr_i,
  input  logic [DATA_WIDTH-1:0]             tree_data_i,
  output logic                              resp_valid_o,
  output logic                              resp_match_o,
  output logic [ADDR_WIDTH-1:0]             resp_addr_o,
  output logic [DATA_WIDTH-1:0]             resp_data_o,
  input  logic                              resp_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   inflight_o,
  output logic [CNT_WIDTH-1:0]              hit_cnt_o,
  output logic [CNT_WIDTH-1:0]              miss_cnt_o,
  output logic                              err_o
);

  localparam int unsigned IF_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic                  tree_valid_q;
  logic [DATA_WIDTH-1:0] tree_data_q;
  logic [IF_W-1:0]       inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  hit_q, miss_q;
  logic                  err_q;

  logic [IF_W-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic [IF_W:0]         used;
  logic                  accept, pop, wr_ok, spurious, ret;

  // Space already promised: buffered results plus lookups still inside the tree.
  assign used        = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign req_ready_o = !rst_i && (used < (IF_W + 1)'(FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign pop         = !fifo_empty && resp_ready_i;
  assign wr_ok       = !fifo_full || pop;
  assign spurious    = tree_valid_i && (inflight_q == '0);
  assign ret         = tree_valid_i && !spurious;
  assign inflight_d  = inflight_q + IF_W'(accept) - IF_W'(ret);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tree_valid_q <= 1'b0;
      tree_data_q  <= '0;
      inflight_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      tree_valid_q <= accept;
      if (accept) tree_data_q <= req_data_i;
      inflight_q <= inflight_d;
      if (tree_valid_i && wr_ok) begin
        if (tree_match_i) begin
          if (hit_q != '1) hit_q <= hit_q + CNT_WIDTH'(1);
        end else begin
          if (miss_q != '1) miss_q <= miss_q + CNT_WIDTH'(1);
        end
      end
      if (spurious || (tree_valid_i && !wr_ok)) err_q <= 1'b1;
    end
  end

  qtree_sc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (tree_valid_i),
    .wdata_i ({tree_match_i, tree_addr_i, tree_data_i}),
    .rd_i    (resp_ready_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tree_valid_o = tree_valid_q;
  assign tree_data_o  = tree_data_q;
  assign resp_valid_o = !fifo_empty;
  assign resp_match_o = fifo_rdata[ENTRY_W-1];
  assign resp_addr_o  = fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
  assign resp_data_o  = fifo_rdata[DATA_WIDTH-1:0];
  assign inflight_o   = inflight_q;
  assign hit_cnt_o    = hit_q;
  assign miss_cnt_o   = miss_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_qtree_lookup_buf.sv
// Bench for qtree_lookup_buf: a queue-based block model checked every cycle, a latency-12
// tree emulator with fault injection, and directed scenarios with literal expectations.
module tb_qtree_lookup_buf;
  import qtree_pkg::*;

  localparam int unsigned DW    = TREE_DATA_WIDTH;
  localparam int unsigned AW    = TREE_ADDR_WIDTH;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IFW   = $clog2(DEPTH + 1);
  localparam int          LAT   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i, req_valid_i, req_ready_o, tree_valid_o, tree_valid_i, tree_match_i;
  logic [DW-1:0]  req_data_i, tree_data_o, tree_data_i, resp_data_o;
  logic [AW-1:0]  tree_addr_i, resp_addr_o;
  logic           resp_valid_o, resp_match_o, resp_ready_i, err_o;
  logic [IFW-1:0] inflight_o;
  logic [31:0]    hit_cnt_o, miss_cnt_o;
  // Second instance with 4-bit counters sees identical traffic to exercise saturation.
  logic           s_req_ready, s_tree_valid, s_resp_valid, s_resp_match, s_err;
  logic [DW-1:0]  s_tree_data, s_resp_data;
  logic [AW-1:0]  s_resp_addr;
  logic [IFW-1:0] s_inflight;
  logic [3:0]     s_hit, s_miss;

  qtree_lookup_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .tree_valid_o(tree_valid_o), .tree_data_o(tree_data_o),
    .tree_valid_i(tree_valid_i), .tree_match_i(tree_match_i), .tree_addr_i(tree_addr_i),
    .tree_data_i(tree_data_i), .resp_valid_o(resp_valid_o), .resp_match_o(resp_match_o),
    .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .inflight_o(inflight_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .err_o(err_o)
  );

  qtree_lookup_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(s_req_ready), .tree_valid_o(s_tree_valid), .tree_data_o(s_tree_data),
    .tree_valid_i(tree_valid_i), .tree_match_i(tree_match_i), .tree_addr_i(tree_addr_i),
    .tree_data_i(tree_data_i), .resp_valid_o(s_resp_valid), .resp_match_o(s_resp_match),
    .resp_addr_o(s_resp_addr), .resp_data_o(s_resp_data), .resp_ready_i(resp_ready_i),
    .inflight_o(s_inflight), .hit_cnt_o(s_hit), .miss_cnt_o(s_miss), .err_o(s_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] tree_addr(input logic [DW-1:0] k);
    return k[AW-1:0] ^ AW'('h2a5a);
  endfunction

  // ---------------- Block model ----------------
  qtree_resp_t   m_q[$];
  qtree_resp_t   m_e;
  int            m_inflight = 0;
  logic [31:0]   m_hit = '0, m_miss = '0;
  bit            m_err = 0, m_tv = 0;
  logic [DW-1:0] m_td = '0;
  bit            m_ready, m_acc, m_pop, m_wr_ok;

  initial forever begin
    @(posedge clk);
    if (rst_i) begin
      m_q.delete();
      m_inflight = 0; m_hit = '0; m_miss = '0; m_err = 0; m_tv = 0; m_td = '0;
    end else begin
      m_ready = (m_q.size() + m_inflight) < DEPTH;
      m_acc   = req_valid_i && m_ready;
      m_pop   = (m_q.size() != 0) && resp_ready_i;
      m_wr_ok = (m_q.size() < DEPTH) || m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (tree_valid_i) begin
        if (m_inflight == 0) m_err = 1;
        else m_inflight--;
        if (m_wr_ok) begin
          m_e.match = tree_match_i; m_e.addr = tree_addr_i; m_e.data = tree_data_i;
          m_q.push_back(m_e);
          if (tree_match_i) m_hit = (m_hit == '1) ? m_hit : m_hit + 1;
          else              m_miss = (m_miss == '1) ? m_miss : m_miss + 1;
        end else begin
          m_err = 1;
        end
      end
      if (m_acc) begin m_inflight++; m_td = req_data_i; end
      m_tv = m_acc;
    end
  end

  // ---------------- Per-cycle compare ----------------
  bit            chk_en = 0;
  int            dut_acc = 0, n_tv_hi = 0;
  logic [DW-1:0] pop_data[$];
  logic          pop_match[$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", req_ready_o, !rst_i && ((m_q.size() + m_inflight) < DEPTH));
      chk("tree_valid", tree_valid_o, m_tv);
      chk("tree_data", tree_data_o, m_td);
      chk("resp_valid", resp_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("resp_match", resp_match_o, m_q[0].match);
        chk("resp_addr", resp_addr_o, m_q[0].addr);
        chk("resp_data", resp_data_o, m_q[0].data);
      end
      chk("inflight", inflight_o, m_inflight);
      chk("hit_cnt", hit_cnt_o, m_hit);
      chk("miss_cnt", miss_cnt_o, m_miss);
      chk("err", err_o, m_err);
      chk("sat_hit", s_hit, (m_hit > 15) ? 15 : m_hit);
      chk("sat_miss", s_miss, (m_miss > 15) ? 15 : m_miss);
      if (req_valid_i && req_ready_o) dut_acc++;
      if (tree_valid_o) n_tv_hi++;
      if (resp_valid_o && resp_ready_i) begin
        pop_data.push_back(resp_data_o);
        pop_match.push_back(resp_match_o);
      end
    end
  end

  // ---------------- Tree emulator (latency LAT, match on even keys) ----------------
  logic          pv[LAT];
  logic [DW-1:0] pd[LAT];
  bit            inj = 0;
  logic          inj_match;
  logic [AW-1:0] inj_addr;
  logic [DW-1:0] inj_data;

  initial begin
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    tree_valid_i = 1'b0; tree_match_i = 1'b0; tree_addr_i = '0; tree_data_i = '0;
    forever begin
      @(posedge clk); #2;
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = tree_valid_o; pd[0] = tree_data_o;
      if (inj) begin
        tree_valid_i = 1'b1; tree_match_i = inj_match;
        tree_addr_i = inj_addr; tree_data_i = inj_data;
        inj = 0;
      end else begin
        tree_valid_i = pv[LAT-1]; tree_match_i = ~pd[LAT-1][0];
        tree_addr_i = tree_addr(pd[LAT-1]); tree_data_i = pd[LAT-1];
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    step(2);
    rst_i = 1'b0;
  endtask

  task automatic inject(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    inj_match = m; inj_addr = a; inj_data = d; inj = 1;
  endtask

  int  acc0;
  bit  found;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0; resp_ready_i = 1'b0;
    do_reset();
    chk_en = 1;

    // Reset then idle
    at_neg();
    chk("idle_ready", req_ready_o, 1);
    chk("idle_tree_valid", tree_valid_o, 0);
    chk("idle_tree_data", tree_data_o, 0);
    chk("idle_resp_valid", resp_valid_o, 0);
    chk("idle_inflight", inflight_o, 0);
    chk("idle_hit", hit_cnt_o, 0);
    chk("idle_miss", miss_cnt_o, 0);
    chk("idle_err", err_o, 0);

    // Four back-to-back keys, responses in order
    step(1);
    resp_ready_i = 1'b1; n_tv_hi = 0; pop_data.delete(); pop_match.delete();
    for (int k = 1; k <= 4; k++) begin req_valid_i = 1'b1; req_data_i = DW'(k); step(1); end
    req_valid_i = 1'b0;
    step(LAT + 8);
    at_neg();
    chk("p1_tree_valid_cycles", n_tv_hi, 4);
    chk("p1_pop_count", pop_data.size(), 4);
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      chk("p1_resp_order", pop_data[i], i + 1);
      chk("p1_resp_match", pop_match[i], (i % 2) == 1);
    end
    chk("p1_hit", hit_cnt_o, 2);
    chk("p1_miss", miss_cnt_o, 2);

    // Credit exhaustion with resp_ready_i low
    do_reset();
    acc0 = dut_acc;
    req_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin req_data_i = DW'('h100 + i); step(1); end
    at_neg();
    chk("p3_accepts", dut_acc - acc0, 16);
    chk("p3_ready_low", req_ready_o, 0);
    chk("p3_inflight_drained", inflight_o, 0);
    chk("p3_model_fifo_full", m_q.size(), 16);
    step(1);
    resp_ready_i = 1'b1; step(1); resp_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin req_data_i = DW'('h180 + i); step(1); end
    at_neg();
    chk("p3_one_more_accept", dut_acc - acc0, 17);
    chk("p3_ready_low_again", req_ready_o, 0);
    step(1);
    req_valid_i = 1'b0; resp_ready_i = 1'b1;
    step(LAT + 24);

    // Simultaneous accept and tree result at inflight 5
    do_reset();
    for (int k = 0; k < 5; k++) begin req_valid_i = 1'b1; req_data_i = DW'('h20 + k); step(1); end
    req_valid_i = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #3;
      if (tree_valid_i) found = 1;
    end
    chk("p4_result_seen", found, 1);
    chk("p4_inflight_before", inflight_o, 5);
    req_valid_i = 1'b1; req_data_i = DW'('h77);
    @(posedge clk); #1; req_valid_i = 1'b0;
    at_neg();
    chk("p4_inflight_after", inflight_o, 5);
    chk("p4_resp_valid", resp_valid_o, 1);
    chk("p4_model_fifo", m_q.size(), 1);
    step(1);
    resp_ready_i = 1'b1;
    step(LAT + 10);

    // Spurious result with nothing in flight
    do_reset();
    step(3);
    chk("p5_err_before", err_o, 0);
    inject(1'b1, AW'('h0abc), DW'('hbeef));
    step(1);
    at_neg();
    chk("p5_err_set", err_o, 1);
    chk("p5_captured", resp_valid_o, 1);
    chk("p5_data", resp_data_o, 'hbeef);
    chk("p5_addr", resp_addr_o, 'h0abc);
    chk("p5_hit", hit_cnt_o, 1);
    chk("p5_inflight", inflight_o, 0);
    step(10);
    resp_ready_i = 1'b1; step(1); resp_ready_i = 1'b0;
    step(5);
    chk("p5_err_sticky", err_o, 1);

    // Forced write into a full FIFO without a pop
    do_reset();
    req_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin req_data_i = DW'('h200 + i); step(1); end
    req_valid_i = 1'b0;
    chk("p6_err_before", err_o, 0);
    chk("p6_hit_before", hit_cnt_o, 8);
    chk("p6_miss_before", miss_cnt_o, 8);
    inject(1'b1, AW'('h1111), DW'('hdead));
    step(1);
    at_neg();
    chk("p6_err_set", err_o, 1);
    chk("p6_hit_kept", hit_cnt_o, 8);
    chk("p6_miss_kept", miss_cnt_o, 8);
    chk("p6_head_kept", resp_data_o, 'h200);
    step(1);
    resp_ready_i = 1'b1;
    step(24);

    // Counter saturation on the 4-bit instance
    do_reset();
    resp_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin req_valid_i = 1'b1; req_data_i = DW'(2 * k); step(1); end
    req_valid_i = 1'b0;
    step(LAT + 8);
    at_neg();
    chk("p7_hit_wide", hit_cnt_o, 20);
    chk("p7_hit_sat", s_hit, 15);
    chk("p7_miss_sat", s_miss, 0);

    // Reset mid-operation with inflight 3 and two buffered results
    step(1);
    do_reset();
    for (int k = 0; k < 2; k++) begin req_valid_i = 1'b1; req_data_i = DW'('h300 + k); step(1); end
    req_valid_i = 1'b0;
    step(LAT + 4);
    for (int k = 2; k < 5; k++) begin req_valid_i = 1'b1; req_data_i = DW'('h300 + k); step(1); end
    req_valid_i = 1'b0;
    chk("p8_inflight_pre", inflight_o, 3);
    chk("p8_model_fifo_pre", m_q.size(), 2);
    rst_i = 1'b1; step(1); rst_i = 1'b0;
    at_neg();
    chk("p8_inflight_cleared", inflight_o, 0);
    chk("p8_resp_cleared", resp_valid_o, 0);
    chk("p8_err_clear", err_o, 0);
    step(LAT + 4);
    chk("p8_late_result_err", err_o, 1);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, want completion", $time);
    $fatal(1);
  end

endmodule
